ecc_xif_initiator: RTL
======================

Name: ecc_xif_initiator

Overview:
- Core-side initiator for the ECC accelerator's CV-X-IF link.
- Accepts one ECC command at a time from a local command port and encodes it as an x_issue request.
- Drives the issue handshake, then collects the matching x_result.
- Returns status and data on a response port; sits between the core and the ECC accelerator.

Parameters:
- TIMEOUT, 1024: cycles to wait in WAIT_RES before aborting with TIMEOUT status; must be >=1.
- CNT_W, $clog2(TIMEOUT+1): width of the timeout counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command ready.
- cmd_op_i  in  3  funct3: 000 MOD, 001 ADD, 010 SUB, 011 MUL.
- cmd_rd_i  in  5  destination register index.
- cmd_a_i  in  64  operand rs[0].
- cmd_b_i  in  64  operand rs[1].
- x_issue_valid_o  out  1  issue request valid.
- x_issue_ready_i  in  1  accelerator ready.
- x_issue_resp_accept_i  in  1  accelerator accepted the instruction.
- x_issue_req_o  out  x_issue_req_t  id, instr, mode, rs, rs_valid.
- x_result_valid_i  in  1  result valid.
- x_result_ready_o  out  1  initiator ready for a result.
- x_result_i  in  x_result_t  id, data, rd, we, exc, exccode.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumer ready.
- rsp_status_o  out  2  00 OK, 01 REJECT, 10 TIMEOUT.
- rsp_data_o  out  64  result data; 0 unless status is OK.
- rsp_we_o  out  1  result write-enable, copied from x_result.we.
- rsp_rd_o  out  5  destination register index.

Behaviour:
- Reset: rst_ni=0 sampled at posedge.
  - State goes to IDLE; id counter goes to 0.
  - All valid/ready outputs go to 0, except cmd_ready_o, which is combinational from IDLE.
  - x_issue_req_o, rsp_* and the timeout counter go to 0.
  - Reset mid-operation aborts the transaction silently; no response is emitted.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i=1, capture the command and build x_issue_req_o:
    - instr = {7'b0, 5'b0, 5'b0, op, rd, ECC_OPCODE}
    - rs[0]=a, rs[1]=b, rs_valid=2'b11, mode=0, id=id counter.
  - Next state ISSUE.
- ISSUE:
  - x_issue_valid_o=1; x_issue_req_o is held stable until handshake (x_issue_valid_o & x_issue_ready_i).
  - At handshake with accept=1: next state WAIT_RES, timeout counter cleared.
  - At handshake with accept=0: next state RESP with REJECT.
  - No timeout applies in ISSUE.
- WAIT_RES:
  - x_result_ready_o=1; the counter increments each cycle.
  - Result with x_result_valid_i=1 and x_result_i.id equal to the issued id:
    - Capture data, we, rd.
    - Status OK, or REJECT if x_result_i.exc=1.
    - Next state RESP.
  - Result with a non-matching id is consumed and dropped; the state is unchanged.
  - When the counter reaches TIMEOUT-1 without a matching result: RESP with TIMEOUT.
  - A matching result on the same cycle as expiry wins; status is OK.
- RESP:
  - rsp_valid_o=1; rsp_* are held until rsp_ready_i.
  - At rsp handshake: id counter increments (wraps modulo 2^X_ID_WIDTH); next state IDLE.
  - rsp_ready_i may already be 1 on the first RESP cycle, giving a one-cycle response.
- Latency: command accept to x_issue_valid_o = 1 cycle. Matching result to rsp_valid_o = 1 cycle.
- At most one outstanding instruction at any time.

Decomposition:
- Package ecc_xif_pkg holds:
  - ECC_OPCODE = 7'b0101011 (custom-1).
  - ecc_op_e enum: MOD, ADD, SUB, MUL.
  - ecc_status_e enum: OK, REJECT, TIMEOUT.
  - Encodings shared with the accelerator decoder.
- The x_issue_req_t, x_issue_resp_t and x_result_t types come from cvxif_pkg.
- One sub-module: ecc_xif_timeout.
  - Inputs: clear, enable.
  - Output: expired pulse.
  - Parameterised by TIMEOUT.

Test Plan:
- ADD: a=5, b=7, rd=3, ready and accept immediate, result data=12, we=1, id=0 after 4 cycles -> instr[14:12]=001 and instr[11:7]=3; rsp OK, data=12, we=1, rd=3; next command uses id=1.
- MOD: a=0xFFFF_FFFF_0000_0001 -> rs[0] carries the value, funct3=000; result we=0, data=0 -> rsp OK, we=0.
- Backpressure/reject: x_issue_ready_i low for 5 cycles -> x_issue_req_o stable throughout. Then ready=1, accept=0 -> rsp REJECT, data=0; id counter increments.
- Timeout: TIMEOUT=16, no result -> rsp TIMEOUT exactly 16 cycles after issue handshake. Matching result on cycle 16 instead -> rsp OK.
- Id mismatch: result with id=5 while id=2 is outstanding -> dropped, no rsp. Later result with id=2 -> rsp OK with that data.
- Wrap/reset:
  - 2^X_ID_WIDTH+1 back-to-back ADDs -> ids wrap to 0.
  - rst_ni low during WAIT_RES -> IDLE, id=0, no rsp_valid_o.

Source files
------------

// File: rtl/cvxif_pkg.sv
// CV-X-IF link types shared by the core-side initiator and the accelerator.
package cvxif_pkg;

  localparam int unsigned X_ID_WIDTH  = 4;
  localparam int unsigned X_NUM_RS    = 2;
  localparam int unsigned X_RFR_WIDTH = 64;
  localparam int unsigned X_RFW_WIDTH = 64;

  typedef struct packed {
    logic [31:0]                             instr;
    logic [1:0]                              mode;
    logic [X_ID_WIDTH-1:0]                   id;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]    rs;
    logic [X_NUM_RS-1:0]                     rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

endpackage

// File: rtl/ecc_xif_pkg.sv
// ECC accelerator encodings shared between the core initiator and the accelerator decoder.
package ecc_xif_pkg;

  localparam logic [6:0] ECC_OPCODE = 7'b0101011;

  typedef enum logic [2:0] {
    OP_MOD = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_MUL = 3'b011
  } ecc_op_e;

  typedef enum logic [1:0] {
    STATUS_OK      = 2'b00,
    STATUS_REJECT  = 2'b01,
    STATUS_TIMEOUT = 2'b10
  } ecc_status_e;

  typedef struct packed {
    ecc_status_e status;
    logic [63:0] data;
    logic        we;
    logic [4:0]  rd;
  } ecc_rsp_t;

endpackage

// File: rtl/ecc_xif_timeout.sv
// Saturating wait counter; expired_c is high while enabled and TIMEOUT-1 cycles have elapsed since clear.
module ecc_xif_timeout #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_limit;

  assign at_limit  = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign expired_c = enable_i & at_limit;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !at_limit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ecc_xif_initiator.sv
// Core-side CV-X-IF initiator: issues one ECC command at a time and returns its result or failure status.
module ecc_xif_initiator
  import cvxif_pkg::*;
  import ecc_xif_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [2:0]   cmd_op_i,
  input  logic [4:0]   cmd_rd_i,
  input  logic [63:0]  cmd_a_i,
  input  logic [63:0]  cmd_b_i,
  output logic         x_issue_valid_o,
  input  logic         x_issue_ready_i,
  input  logic         x_issue_resp_accept_i,
  output x_issue_req_t x_issue_req_o,
  input  logic         x_result_valid_i,
  output logic         x_result_ready_o,
  input  x_result_t    x_result_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [1:0]   rsp_status_o,
  output logic [63:0]  rsp_data_o,
  output logic         rsp_we_o,
  output logic [4:0]   rsp_rd_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, RESP} state_e;

  state_e                state_q, state_d;
  logic [X_ID_WIDTH-1:0] id_q, id_d;
  x_issue_req_t          req_q, req_d;
  ecc_rsp_t              rsp_q, rsp_d;
  logic                  issue_valid_q, issue_valid_d;
  logic                  res_ready_q, res_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  tmo_clear, tmo_en, tmo_expired;
  logic                  res_match;
  logic                  unused_exccode;

  assign unused_exccode = ^x_result_i.exccode;
  assign res_match      = x_result_valid_i && (x_result_i.id == req_q.id);

  ecc_xif_timeout #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (tmo_clear),
    .enable_i  (tmo_en),
    .expired_c (tmo_expired)
  );

  // Next-state and output register inputs
  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    req_d         = req_q;
    rsp_d         = rsp_q;
    issue_valid_d = issue_valid_q;
    res_ready_d   = res_ready_q;
    rsp_valid_d   = rsp_valid_q;
    tmo_clear     = 1'b0;
    tmo_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          req_d.instr    = {7'b0, 5'b0, 5'b0, cmd_op_i, cmd_rd_i, ECC_OPCODE};
          req_d.mode     = 2'b00;
          req_d.id       = id_q;
          req_d.rs[0]    = cmd_a_i;
          req_d.rs[1]    = cmd_b_i;
          req_d.rs_valid = 2'b11;
          rsp_d.rd       = cmd_rd_i;
          issue_valid_d  = 1'b1;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        if (x_issue_ready_i) begin
          issue_valid_d = 1'b0;
          if (x_issue_resp_accept_i) begin
            tmo_clear   = 1'b1;
            res_ready_d = 1'b1;
            state_d     = WAIT_RES;
          end else begin
            rsp_d.status = STATUS_REJECT;
            rsp_d.data   = '0;
            rsp_d.we     = 1'b0;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
          end
        end
      end
      WAIT_RES: begin
        tmo_en = 1'b1;
        // A matching result takes priority over expiry in the same cycle
        if (res_match) begin
          rsp_d.status = x_result_i.exc ? STATUS_REJECT : STATUS_OK;
          rsp_d.data   = x_result_i.exc ? '0 : x_result_i.data;
          rsp_d.we     = x_result_i.we;
          rsp_d.rd     = x_result_i.rd;
          res_ready_d  = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else if (tmo_expired) begin
          rsp_d.status = STATUS_TIMEOUT;
          rsp_d.data   = '0;
          rsp_d.we     = 1'b0;
          res_ready_d  = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          id_d        = id_q + X_ID_WIDTH'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      id_q          <= '0;
      req_q         <= '0;
      rsp_q         <= '0;
      issue_valid_q <= 1'b0;
      res_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      req_q         <= req_d;
      rsp_q         <= rsp_d;
      issue_valid_q <= issue_valid_d;
      res_ready_q   <= res_ready_d;
      rsp_valid_q   <= rsp_valid_d;
    end
  end

  assign cmd_ready_o      = (state_q == IDLE);
  assign x_issue_valid_o  = issue_valid_q;
  assign x_issue_req_o    = req_q;
  assign x_result_ready_o = res_ready_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_status_o     = rsp_q.status;
  assign rsp_data_o       = rsp_q.data;
  assign rsp_we_o         = rsp_q.we;
  assign rsp_rd_o         = rsp_q.rd;

endmodule
